rescale_arbiter: RTL and testbench
==================================

Name: rescale_arbiter

Overview:
- Shares one shift/saturate requantization pipeline between NUM_REQ accumulator producers, such as parallel conv/FC channel engines.
- Arbitrates round-robin over valid/ready requesters and applies a per-requester runtime shift amount.
- Emits int8 results tagged with the source ID.
- Counts results per requester and pulses a per-requester done flag at end of frame. Sits between MAC arrays and the activation buffer writer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; equals clog2(NUM_REQ).
- DEFAULT_SHIFT, 11, per-requester shift value after reset (0..31).
- FRAME_LEN, 64, results per requester per frame; done pulses when this count is reached.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester data valid
- req_data  in  32*NUM_REQ  signed accumulators; requester i occupies bits [32i+31:32i]
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- cfg_we  in  1  shift-config write strobe
- cfg_id  in  ID_W  config target requester
- cfg_shift  in  5  shift amount to write
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  8  signed saturated result
- out_id  out  ID_W  source requester of out_data
- frame_done  out  NUM_REQ  one-cycle pulse per requester at frame end

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. On rst:
  - out_valid=0, out_data=0, out_id=0, frame_done=0, req_ready=0.
  - RR pointer=0.
  - All shift registers=DEFAULT_SHIFT.
  - All frame counters=0.
  - Both pipeline stages invalid; any in-flight items are discarded.
- Pipeline: two register stages.
  - S1 holds accumulator, ID and captured shift.
  - S2 is the output register.
  - Latency is 2 cycles from acceptance to out_valid when there is no backpressure. Throughput is 1 result per cycle.
- Stall rules:
  - s2_adv = ~out_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - Arbitration occurs only when s1_adv=1.
- Arbitration:
  - grant = first i at or after the RR pointer, modulo NUM_REQ, with req_valid[i]=1.
  - req_ready[i] = s1_adv & grant[i], combinational.
  - A transfer on requester g sets pointer = (g+1) mod NUM_REQ. With no transfer, the pointer holds.
- Shift configuration:
  - The shift value is captured into S1 at acceptance.
  - A cfg_we in the same cycle as acceptance for the same ID: the accepted item uses the OLD shift. The new shift is visible from the next cycle.
  - Config writes never stall the pipeline.
- Arithmetic (S1→S2):
  - t = acc >>> shift, full 32-bit arithmetic shift with floor rounding.
  - Saturation compares the full 32-bit t: t<-128 → -128; t>127 → 127; else t[7:0]. No truncation before comparison.
- Output: out_data/out_id hold stable while out_valid & ~out_ready.
- Frame counting:
  - counter[id] increments when an S2 result for that id is accepted (out_valid & out_ready).
  - On reaching FRAME_LEN-1 and accepting: frame_done[id] pulses in the following cycle and the counter wraps to 0.
  - Multiple frame_done bits may pulse in the same cycle only across different IDs.
- Edge cases:
  - All req_valid=0: no grant, and the pointer holds.
  - A single requester streams back-to-back at full rate.

Optional Feature:
- Macro RESCALE_ARB_RELU_EN.
- When defined: negative saturated results are forced to 0, so the output range is [0,127], fused ReLU.
- When undefined: signed output range [-128,127], shift-only.
- Latency is unchanged in both cases.

Decomposition:
- Shared package holds:
  - ACC_W=32, OUT_W=8, SHIFT_W=5.
  - Constants OUT_MAX=127, OUT_MIN=-128.
  - The req_id typedef.
- One natural sub-module: rescale_sat_stage. It is the registered shift+saturate+optional-ReLU stage with an enable input, instantiated as S2.
- Arbiter, config registers and counters stay in the top level.

Test Plan:
- Reset then single requester 0, acc=0x0000_2800, shift 11 → out_data=5, out_id=0, out_valid 2 cycles after the req_ready handshake.
- Saturation, requester 1 at shift 11: acc=0x7FFF_FFFF → 127; acc=0x8000_0000 → -128 (0 with RELU_EN); acc=-2048 → -1.
- All 4 requesters constantly valid, out_ready=1 → grants 0,1,2,3,0,…; one result per cycle; IDs in the same order.
- out_ready low for 5 cycles with a full pipeline → out_data/out_id stable, req_ready all 0 after S1 fills, no loss or duplication after release.
- cfg_we id=2 shift=4 in the same cycle requester 2 is accepted with acc=256 → that result is 0 (old shift 11); the next acc=256 → 16.
- FRAME_LEN=64 results accepted on requester 3 → frame_done[3] pulses exactly once for one cycle after the 64th acceptance; the counter restarts; rst mid-frame clears the count.

Source files
------------

// File: rtl/rescale_arbiter_pkg.sv
// Shared widths, output limits and requester-id type for the rescale arbiter.
package rescale_arbiter_pkg;
  localparam int ACC_W    = 32;
  localparam int OUT_W    = 8;
  localparam int SHIFT_W  = 5;
  localparam int OUT_MAX  = 127;
  localparam int OUT_MIN  = -128;
  localparam int MAX_ID_W = 3;

  // Wide enough for any supported requester count (up to 8).
  typedef logic [MAX_ID_W-1:0] req_id_t;
endpackage

// File: rtl/rescale_sat_stage.sv
// Registered shift + saturate stage (output register of the pipeline).
// Optional fused ReLU when RESCALE_ARB_RELU_EN is defined.
module rescale_sat_stage
  import rescale_arbiter_pkg::*;
#(
  parameter int ID_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               vld_in,
  input  logic [ACC_W-1:0]   acc_in,
  input  logic [SHIFT_W-1:0] shift_in,
  input  logic [ID_W-1:0]    id_in,
  output logic               vld_out,
  output logic [OUT_W-1:0]   data_out,
  output logic [ID_W-1:0]    id_out
);

  logic                    vld_p2;
  logic signed [OUT_W-1:0] data_p2;
  logic [ID_W-1:0]         id_p2;
  logic signed [OUT_W-1:0] res_nxt;

  // Saturation looks at the full shifted word so large values never wrap.
  function automatic logic signed [OUT_W-1:0] sat_shift(
    input logic signed [ACC_W-1:0] acc,
    input logic [SHIFT_W-1:0]      sh
  );
    logic signed [ACC_W-1:0] t;
    logic signed [OUT_W-1:0] r;
    t = acc >>> sh;
    if (t > OUT_MAX)      r = OUT_W'(OUT_MAX);
    else if (t < OUT_MIN) r = OUT_W'(OUT_MIN);
    else                  r = t[OUT_W-1:0];
    return r;
  endfunction

  function automatic logic signed [OUT_W-1:0] relu(input logic signed [OUT_W-1:0] v);
`ifdef RESCALE_ARB_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign res_nxt = relu(sat_shift($signed(acc_in), shift_in));

  // S1 -> S2 boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      id_p2   <= '0;
    end else if (en) begin
      vld_p2 <= vld_in;
      if (vld_in) begin
        data_p2 <= res_nxt;
        id_p2   <= id_in;
      end
    end
  end

  assign vld_out  = vld_p2;
  assign data_out = data_p2;
  assign id_out   = id_p2;

endmodule

// File: rtl/rescale_arbiter.sv
// Round-robin arbiter feeding a shared 2-stage shift/saturate requantizer,
// with per-requester shift config and frame counters. Macro: RESCALE_ARB_RELU_EN.
module rescale_arbiter
  import rescale_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int DEFAULT_SHIFT = 11,
  parameter int FRAME_LEN     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [ACC_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     cfg_we,
  input  logic [ID_W-1:0]          cfg_id,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [ID_W-1:0]          out_id,
  output logic [NUM_REQ-1:0]       frame_done
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  logic [SHIFT_W-1:0] shift_cfg [NUM_REQ];
  logic [CNT_W-1:0]   frame_cnt [NUM_REQ];
  req_id_t            rr_ptr;

  logic               gnt_vld;
  logic [ID_W-1:0]    gnt_id;
  int                 idx;
  logic               accept;
  logic               s1_adv;
  logic               s2_adv;

  logic                    vld_p1;
  logic signed [ACC_W-1:0] acc_p1;
  logic [ID_W-1:0]         id_p1;
  logic [SHIFT_W-1:0]      shift_p1;

  assign s2_adv = ~out_valid | out_ready;
  assign s1_adv = ~vld_p1 | s2_adv;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_vld && req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
  end

  assign accept = gnt_vld & s1_adv & ~rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_id] = 1'b1;
  end

  // Control: pointer, S1 valid and shift config. The accepted item reads the
  // shift register before any same-cycle write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      vld_p1 <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) shift_cfg[i] <= SHIFT_W'(DEFAULT_SHIFT);
    end else begin
      if (accept) rr_ptr <= req_id_t'((int'(gnt_id) + 1) % NUM_REQ);
      if (s1_adv) vld_p1 <= accept;
      if (cfg_we) shift_cfg[cfg_id] <= cfg_shift;
    end
  end

  // Input -> S1 boundary
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_p1   <= $signed(req_data[ACC_W*int'(gnt_id) +: ACC_W]);
      id_p1    <= gnt_id;
      shift_p1 <= shift_cfg[gnt_id];
    end
  end

  rescale_sat_stage #(
    .ID_W (ID_W)
  ) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .en       (s2_adv),
    .vld_in   (vld_p1),
    .acc_in   (acc_p1),
    .shift_in (shift_p1),
    .id_in    (id_p1),
    .vld_out  (out_valid),
    .data_out (out_data),
    .id_out   (out_id)
  );

  // Count accepted results per source; done pulses the cycle after the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= '0;
      for (int i = 0; i < NUM_REQ; i++) frame_cnt[i] <= '0;
    end else begin
      frame_done <= '0;
      if (out_valid && out_ready) begin
        if (frame_cnt[out_id] == CNT_W'(FRAME_LEN - 1)) begin
          frame_cnt[out_id]  <= '0;
          frame_done[out_id] <= 1'b1;
        end else begin
          frame_cnt[out_id] <= frame_cnt[out_id] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rescale_arbiter.sv
// Directed, table-driven bench for rescale_arbiter (default parameters).
module tb_rescale_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         cfg_we;
  logic [1:0]   cfg_id;
  logic [4:0]   cfg_shift;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic [1:0]   out_id;
  logic [3:0]   frame_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rescale_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .cfg_we     (cfg_we),
    .cfg_id     (cfg_id),
    .cfg_shift  (cfg_shift),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .frame_done (frame_done)
  );

  typedef struct {
    int          id;
    logic [31:0] acc;
    int          exp;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int relu_exp(input int v);
`ifdef RESCALE_ARB_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    cfg_we = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic stream3(input int n, input int exp_pulse_after);
    int sent, outs, pulses, cyc;
    logic exp_next, fire_in, fire_out;
    sent = 0; outs = 0; pulses = 0; cyc = 0; exp_next = 1'b0;
    out_ready = 1'b1;
    req_data[96 +: 32] = 32'h0000_1800;
    while ((sent < n || outs < n || exp_next) && cyc < n + 20) begin
      req_valid = (sent < n) ? 4'b1000 : 4'b0000;
      #1;
      check("frame_done", {28'd0, frame_done}, exp_next ? 32'd8 : 32'd0);
      if (frame_done[3]) pulses++;
      fire_in  = req_ready[3];
      fire_out = out_valid && out_ready;
      exp_next = fire_out && (outs + 1 == exp_pulse_after);
      tick();
      if (fire_in) sent++;
      if (fire_out) outs++;
      cyc++;
    end
    req_valid = '0;
    check("frame_outputs", outs, n);
    check("frame_pulses", pulses, (exp_pulse_after != 0) ? 1 : 0);
  endtask

  initial begin
    vecs[0]  = '{1, 32'h7FFF_FFFF, 127};
    vecs[1]  = '{1, 32'h8000_0000, relu_exp(-128)};
    vecs[2]  = '{1, 32'hFFFF_F800, relu_exp(-1)};
    vecs[3]  = '{2, 32'h0003_F800, 127};
    vecs[4]  = '{2, 32'h0004_0000, 127};
    vecs[5]  = '{2, 32'hFFFC_0000, relu_exp(-128)};
    vecs[6]  = '{2, 32'hFFFB_F800, relu_exp(-128)};
    vecs[7]  = '{0, 32'h0008_0000, 127};
    vecs[8]  = '{3, 32'hFFFF_FFFF, relu_exp(-1)};
    vecs[9]  = '{3, 32'h0000_07FF, 0};
    vecs[10] = '{0, 32'h0003_F7FF, 126};

    // Reset state with a requester already asserting valid
    rst = 1'b1; cfg_we = 1'b0; cfg_id = '0; cfg_shift = '0;
    out_ready = 1'b1; req_data = '0;
    req_valid = 4'b0001;
    req_data[31:0] = 32'h0000_2800;
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_id", {30'd0, out_id}, 32'd0);
    check("rst_frame_done", {28'd0, frame_done}, 32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("first_ready", {28'd0, req_ready}, 32'd1);
    tick();
    req_valid = '0;
    #1;
    check("first_lat1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("first_valid", {31'd0, out_valid}, 32'd1);
    check("first_data", {{24{out_data[7]}}, out_data}, 32'd5);
    check("first_id", {30'd0, out_id}, 32'd0);
    tick();
    check("first_drained", {31'd0, out_valid}, 32'd0);

    // Saturation / rounding vectors, one item at a time
    for (int v = 0; v < 11; v++) begin
      req_data[32*vecs[v].id +: 32] = vecs[v].acc;
      req_valid = 4'b0001 << vecs[v].id;
      #1;
      check("vec_ready", {28'd0, req_ready}, 32'd1 << vecs[v].id);
      tick();
      req_valid = '0;
      tick();
      check("vec_valid", {31'd0, out_valid}, 32'd1);
      check("vec_data", {{24{out_data[7]}}, out_data}, vecs[v].exp);
      check("vec_id", {30'd0, out_id}, vecs[v].id);
      tick();
    end

    // Round-robin with all requesters valid
    do_reset();
    for (int i = 0; i < 4; i++) req_data[32*i +: 32] = (i + 1) << 11;
    out_ready = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("rr_ready", {28'd0, req_ready}, 32'd1 << (k % 4));
      check("rr_valid", {31'd0, out_valid}, (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        check("rr_id", {30'd0, out_id}, (k - 2) % 4);
        check("rr_data", {24'd0, out_data}, ((k - 2) % 4) + 1);
      end
      tick();
    end

    // Backpressure with a full pipeline: S2 holds id0, S1 holds id1
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_id", {30'd0, out_id}, 32'd0);
      check("bp_data", {24'd0, out_data}, 32'd1);
      check("bp_ready", {28'd0, req_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {28'd0, req_ready}, 32'd4);
    for (int j = 0; j < 6; j++) begin
      #1;
      check("bp_post_id", {30'd0, out_id}, j % 4);
      check("bp_post_data", {24'd0, out_data}, (j % 4) + 1);
      tick();
    end
    req_valid = '0;
    tick(); tick(); tick();

    // Same-cycle config write uses the old shift
    do_reset();
    req_data[64 +: 32] = 32'd256;
    req_valid = 4'b0100;
    cfg_we = 1'b1; cfg_id = 2'd2; cfg_shift = 5'd4;
    #1;
    check("cfg_ready0", {28'd0, req_ready}, 32'd4);
    tick();
    cfg_we = 1'b0;
    #1;
    check("cfg_ready1", {28'd0, req_ready}, 32'd4);
    tick();
    req_valid = '0;
    #1;
    check("cfg_old_valid", {31'd0, out_valid}, 32'd1);
    check("cfg_old_data", {24'd0, out_data}, 32'd0);
    tick();
    check("cfg_new_valid", {31'd0, out_valid}, 32'd1);
    check("cfg_new_data", {24'd0, out_data}, 32'd16);
    tick();

    // Frame counting, wrap and mid-frame reset on requester 3
    do_reset();
    stream3(64, 64);
    stream3(63, 0);
    stream3(1, 1);
    stream3(10, 0);
    do_reset();
    stream3(63, 0);
    stream3(1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
